npc_predict_unit: RTL and testbench
===================================

Name: npc_predict_unit

Overview:
- Next-generation next-PC unit: merges next-PC priority selection with an integrated, parametrised direct-mapped branch target buffer (BTB) and saturating-counter direction predictor.
- Sits between the hazard unit and the IF stage register; PC_In feeds the PC register.
- Lookup happens in IF; training and mispredict resolution happen in EX.
- Adds performance counters for executed branches and mispredicts.

Parameters:
ENTRIES, 16, BTB/counter entries; power of two, >=2; IDX_W = log2(ENTRIES)
CNT_BITS, 2, saturating counter width, >=1 (1 = last-outcome predictor)
STAT_W, 32, width of performance counters

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset; synchronous and active-high
PCF  in  32  IF-stage PC, lookup address
PCE  in  32  EX-stage PC of the instruction being resolved
JalrTarget  in  32  resolved JALR target (EX)
BranchTarget  in  32  resolved conditional-branch target (EX)
JalTarget  in  32  JAL target (ID)
JalD  in  1  JAL in ID
JalrE  in  1  JALR in EX
BranchInstrE  in  1  EX holds a conditional branch
BranchE  in  1  EX branch condition true (taken)
PredTakenE  in  1  PredTakenF value piped to EX with this instruction
StallE  in  1  EX stalled; suppresses training and statistics
PC_In  out  32  next PC (combinational)
PredHitF  out  1  BTB hit for PCF (combinational)
PredTakenF  out  1  predict taken for PCF (combinational)
PredTargetF  out  32  predicted target for PCF (combinational)
MispredictE  out  1  EX direction mispredict; hazard unit flushes ID/EX on it
BranchCnt  out  STAT_W  executed conditional branches
MispredCnt  out  STAT_W  mispredicted conditional branches

Behaviour:
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], cnt[CNT_BITS-1:0]. Index = PC[IDX_W+1:2].
- IF lookup, combinational:
  - PredHitF = valid[idxF] && tag[idxF] == tagF.
  - PredTakenF = PredHitF && cnt[idxF][MSB].
  - PredTargetF = target[idxF] on hit, else PCF+4.
- MispredictE = BranchInstrE && (BranchE != PredTakenE). Not gated by StallE.
- PC_In priority, highest first:
  1. JalrE -> JalrTarget
  2. BranchInstrE && BranchE && !PredTakenE -> BranchTarget
  3. BranchInstrE && !BranchE && PredTakenE -> PCE+4
  4. JalD -> JalTarget
  5. PredTakenF -> PredTargetF
  6. otherwise PCF+4
- All adds are modulo 2^32.
- EX training, when BranchInstrE && !StallE, on the next edge. hitE is recomputed from the current array at idxE/tagE:
  - hitE: cnt saturating +1 if BranchE, -1 if not. Saturates at all-ones and 0. If BranchE, target <= BranchTarget.
  - !hitE && BranchE: allocate/replace the entry. valid=1, tag=tagE, target=BranchTarget, cnt = 2^(CNT_BITS-1) (weakly taken).
  - !hitE && !BranchE: no array change.
- Statistics, when BranchInstrE && !StallE:
  - BranchCnt +1.
  - MispredCnt +1 if MispredictE.
  - Both saturate at all-ones; no wrap.
- Same-cycle IF lookup and EX write to the same index: IF sees the pre-write contents. The write is visible the next cycle. No bypass.
- JalrE is not predicted and does not train. JAL is not stored in the BTB.
- Reset (rst high at an edge, including mid-operation):
  - all valid <= 0, cnt <= 0, target <= 0, tag <= 0.
  - BranchCnt, MispredCnt <= 0.
  - In the cycle after reset, PredHitF = 0, PredTakenF = 0, PredTargetF = PCF+4.
  - Combinational outputs (PC_In, MispredictE) keep following their inputs during reset.
- Training latency: 1 cycle. A lookup in cycle N+1 sees an update issued in cycle N.

Decomposition:
- Shared package: IDX_W derivation function; counter constants CNT_MAX, CNT_INIT; entry struct typedef (valid, tag, target, cnt).
- One natural sub-module: npc_btb_array, holding the storage, two read ports (F, E) and one write port.
- The top holds the counter update logic, next-PC mux and statistics.

Test Plan (ENTRIES=16, CNT_BITS=2):
1. After reset, PCF=0x100, no control inputs -> PredHitF=0, PC_In=0x104; BranchCnt=0, MispredCnt=0.
2. Branch at PCE=0x100, BranchE=1, PredTakenE=0, BranchTarget=0x80 -> same cycle: MispredictE=1, PC_In=0x80. Next cycle, PCF=0x100 -> PredHitF=1, PredTakenF=1, PC_In=0x80. MispredCnt=1.
3. Same branch resolved not-taken with PredTakenE=1 -> MispredictE=1, PC_In=0x104, cnt 2->1. Next lookup at 0x100: PredTakenF=0, PC_In=0x104.
4. Train taken 3 times -> cnt saturates at 3. One not-taken -> cnt=2, still predicts taken.
5. Aliasing: allocate 0x100, then a taken branch at 0x140 (same idx 0) -> entry replaced. Lookup 0x100 -> miss; lookup 0x140 -> hit.
6. Priority and stall:
   - JalrE=1, JalD=1 and a branch mispredict all asserted -> PC_In=JalrTarget.
   - StallE=1 with BranchInstrE=1 -> counters and array unchanged.
   - rst mid-run -> all subsequent lookups miss.

Source files
------------

// File: rtl/npc_predict_unit_pkg.sv
// Shared types and helpers for the next-PC / branch prediction unit.
// Entry fields are sized for the widest legal configuration; narrower
// configurations leave the upper tag/counter bits at zero.
package npc_predict_unit_pkg;

    localparam int TAG_MAX_W = 30;
    localparam int CNT_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [CNT_MAX_W-1:0] cnt;
    } btbEntry_t;

    function automatic int calcIdxW(input int entries);
        return $clog2(entries);
    endfunction

    function automatic logic [CNT_MAX_W-1:0] cntMaxOf(input int cntBits);
        int v;
        v = (1 << cntBits) - 1;
        return v[CNT_MAX_W-1:0];
    endfunction

    function automatic logic [CNT_MAX_W-1:0] cntInitOf(input int cntBits);
        int v;
        v = 1 << (cntBits - 1);
        return v[CNT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/npc_btb_array.sv
// Direct-mapped BTB storage: two asynchronous read ports (IF lookup and
// EX training) and a single write port. Reads never bypass a pending write.
module npc_btb_array
    import npc_predict_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_idxF,
    output btbEntry_t        o_entryF,
    input  logic [IDX_W-1:0] i_idxE,
    output btbEntry_t        o_entryE,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  btbEntry_t        i_wentry
);

    btbEntry_t r_mem [ENTRIES];

    // Clear every entry on reset, otherwise commit the single EX write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wentry;
        end
    end

    assign o_entryF = r_mem[i_idxF];
    assign o_entryE = r_mem[i_idxE];

endmodule

// File: rtl/npc_predict_unit.sv
// Next-PC selection with an integrated direct-mapped BTB and saturating
// direction counters. Lookup in IF, training and redirect in EX, plus
// saturating counters of executed and mispredicted conditional branches.
module npc_predict_unit
    import npc_predict_unit_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int STAT_W   = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PCF,
    input  logic [31:0]       PCE,
    input  logic [31:0]       JalrTarget,
    input  logic [31:0]       BranchTarget,
    input  logic [31:0]       JalTarget,
    input  logic              JalD,
    input  logic              JalrE,
    input  logic              BranchInstrE,
    input  logic              BranchE,
    input  logic              PredTakenE,
    input  logic              StallE,
    output logic [31:0]       PC_In,
    output logic              PredHitF,
    output logic              PredTakenF,
    output logic [31:0]       PredTargetF,
    output logic              MispredictE,
    output logic [STAT_W-1:0] BranchCnt,
    output logic [STAT_W-1:0] MispredCnt
);

    localparam int                   IDX_W    = calcIdxW(ENTRIES);
    localparam logic [CNT_MAX_W-1:0] CNT_MAX  = cntMaxOf(CNT_BITS);
    localparam logic [CNT_MAX_W-1:0] CNT_INIT = cntInitOf(CNT_BITS);

    logic [IDX_W-1:0]     w_idxF;
    logic [IDX_W-1:0]     w_idxE;
    logic [TAG_MAX_W-1:0] w_tagF;
    logic [TAG_MAX_W-1:0] w_tagE;
    btbEntry_t            w_entryF;
    btbEntry_t            w_entryE;
    btbEntry_t            w_wentry;
    logic                 w_we;
    logic                 w_hitE;
    logic                 w_train;
    logic [31:0]          w_pcF4;
    logic [31:0]          w_pcE4;
    logic [STAT_W-1:0]    r_branchCnt;
    logic [STAT_W-1:0]    r_mispredCnt;

    assign w_idxF  = PCF[IDX_W+1:2];
    assign w_idxE  = PCE[IDX_W+1:2];
    assign w_tagF  = TAG_MAX_W'(PCF >> (IDX_W + 2));
    assign w_tagE  = TAG_MAX_W'(PCE >> (IDX_W + 2));
    assign w_pcF4  = PCF + 32'd4;
    assign w_pcE4  = PCE + 32'd4;

    npc_btb_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk      (clk),
        .rst      (rst),
        .i_idxF   (w_idxF),
        .o_entryF (w_entryF),
        .i_idxE   (w_idxE),
        .o_entryE (w_entryE),
        .i_we     (w_we),
        .i_widx   (w_idxE),
        .i_wentry (w_wentry)
    );

    assign PredHitF    = w_entryF.valid && (w_entryF.tag == w_tagF);
    assign PredTakenF  = PredHitF && w_entryF.cnt[CNT_BITS-1];
    assign PredTargetF = PredHitF ? w_entryF.target : w_pcF4;

    assign MispredictE = BranchInstrE && (BranchE != PredTakenE);
    assign w_hitE      = w_entryE.valid && (w_entryE.tag == w_tagE);
    assign w_train     = BranchInstrE && !StallE;

    // Next-PC priority: EX redirects beat the ID jump, which beats prediction
    always_comb begin
        PC_In = w_pcF4;
        if (JalrE) begin
            PC_In = JalrTarget;
        end else if (BranchInstrE && BranchE && !PredTakenE) begin
            PC_In = BranchTarget;
        end else if (BranchInstrE && !BranchE && PredTakenE) begin
            PC_In = w_pcE4;
        end else if (JalD) begin
            PC_In = JalTarget;
        end else if (PredTakenF) begin
            PC_In = PredTargetF;
        end
    end

    // Build the EX write: counter step on a hit, allocate on a taken miss
    always_comb begin
        w_we     = 1'b0;
        w_wentry = w_entryE;
        if (w_train) begin
            if (w_hitE) begin
                w_we = 1'b1;
                if (BranchE) begin
                    w_wentry.target = BranchTarget;
                    if (w_entryE.cnt != CNT_MAX) begin
                        w_wentry.cnt = w_entryE.cnt + CNT_MAX_W'(1);
                    end
                end else if (w_entryE.cnt != '0) begin
                    w_wentry.cnt = w_entryE.cnt - CNT_MAX_W'(1);
                end
            end else if (BranchE) begin
                w_we            = 1'b1;
                w_wentry.valid  = 1'b1;
                w_wentry.tag    = w_tagE;
                w_wentry.target = BranchTarget;
                w_wentry.cnt    = CNT_INIT;
            end
        end
    end

    // Saturating branch and mispredict statistics, frozen while EX stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branchCnt  <= '0;
            r_mispredCnt <= '0;
        end else if (w_train) begin
            if (r_branchCnt != '1) begin
                r_branchCnt <= r_branchCnt + STAT_W'(1);
            end
            if (MispredictE && (r_mispredCnt != '1)) begin
                r_mispredCnt <= r_mispredCnt + STAT_W'(1);
            end
        end
    end

    assign BranchCnt  = r_branchCnt;
    assign MispredCnt = r_mispredCnt;

endmodule

// File: tb/tb_npc_predict_unit.sv
// Self-checking bench for npc_predict_unit (ENTRIES=16, CNT_BITS=2).
// A behavioural model tracks BTB contents as plain per-index arrays.
module tb_npc_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCE, JalrTarget, BranchTarget, JalTarget;
    logic        JalD, JalrE, BranchInstrE, BranchE, PredTakenE, StallE;
    logic [31:0] PC_In, PredTargetF;
    logic        PredHitF, PredTakenF, MispredictE;
    logic [31:0] BranchCnt, MispredCnt;

    int vecCount  = 0;
    int missCount = 0;

    bit          mValid [16];
    int unsigned mTag   [16];
    logic [31:0] mTgt   [16];
    int          mCnt   [16];
    int unsigned mBr, mMis;

    npc_predict_unit #(
        .ENTRIES  (16),
        .CNT_BITS (2),
        .STAT_W   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PCF          (PCF),
        .PCE          (PCE),
        .JalrTarget   (JalrTarget),
        .BranchTarget (BranchTarget),
        .JalTarget    (JalTarget),
        .JalD         (JalD),
        .JalrE        (JalrE),
        .BranchInstrE (BranchInstrE),
        .BranchE      (BranchE),
        .PredTakenE   (PredTakenE),
        .StallE       (StallE),
        .PC_In        (PC_In),
        .PredHitF     (PredHitF),
        .PredTakenF   (PredTakenF),
        .PredTargetF  (PredTargetF),
        .MispredictE  (MispredictE),
        .BranchCnt    (BranchCnt),
        .MispredCnt   (MispredCnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit mHit(input logic [31:0] pc);
        return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
    endfunction

    function automatic bit mTaken(input logic [31:0] pc);
        return mHit(pc) && (mCnt[idxOf(pc)] >= 2);
    endfunction

    function automatic logic [31:0] mTarget(input logic [31:0] pc);
        return mHit(pc) ? mTgt[idxOf(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] expPcIn();
        if (JalrE) return JalrTarget;
        if (BranchInstrE && BranchE && !PredTakenE) return BranchTarget;
        if (BranchInstrE && !BranchE && PredTakenE) return PCE + 32'd4;
        if (JalD) return JalTarget;
        if (mTaken(PCF)) return mTarget(PCF);
        return PCF + 32'd4;
    endfunction

    // Apply what the DUT should do at the clock edge with the current inputs
    task automatic modelCommit();
        int i;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                mValid[k] = 0; mTag[k] = 0; mTgt[k] = '0; mCnt[k] = 0;
            end
            mBr = 0; mMis = 0;
        end else if (BranchInstrE && !StallE) begin
            mBr++;
            if (BranchE != PredTakenE) mMis++;
            i = idxOf(PCE);
            if (mHit(PCE)) begin
                if (BranchE) begin
                    if (mCnt[i] < 3) mCnt[i]++;
                    mTgt[i] = BranchTarget;
                end else if (mCnt[i] > 0) begin
                    mCnt[i]--;
                end
            end else if (BranchE) begin
                mValid[i] = 1; mTag[i] = tagOf(PCE);
                mTgt[i] = BranchTarget; mCnt[i] = 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    task automatic clearInputs();
        JalD = 0; JalrE = 0; BranchInstrE = 0; BranchE = 0;
        PredTakenE = 0; StallE = 0;
        PCE = '0; JalrTarget = '0; BranchTarget = '0; JalTarget = '0;
    endtask

    task automatic test_reset();
        clearInputs();
        PCF = 32'h100;
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        vecCount++; if (PredHitF !== 1'b0) begin missCount++; $display("FAIL reset_hit got %b want 0", PredHitF); end
        vecCount++; if (PC_In !== 32'h104) begin missCount++; $display("FAIL reset_pcin got %h want 00000104", PC_In); end
        vecCount++; if (PredTargetF !== 32'h104) begin missCount++; $display("FAIL reset_tgt got %h want 00000104", PredTargetF); end
        vecCount++; if (BranchCnt !== 32'd0) begin missCount++; $display("FAIL reset_brcnt got %0d want 0", BranchCnt); end
        vecCount++; if (MispredCnt !== 32'd0) begin missCount++; $display("FAIL reset_miscnt got %0d want 0", MispredCnt); end
    endtask

    task automatic test_mispredict();
        // Taken branch that was predicted not-taken allocates the entry
        clearInputs();
        PCF = 32'h104; PCE = 32'h100; BranchInstrE = 1; BranchE = 1; BranchTarget = 32'h80;
        #1;
        vecCount++; if (MispredictE !== 1'b1) begin missCount++; $display("FAIL mis_taken got %b want 1", MispredictE); end
        vecCount++; if (PC_In !== 32'h80) begin missCount++; $display("FAIL mis_taken_pc got %h want 00000080", PC_In); end
        tick();
        clearInputs(); PCF = 32'h100; #1;
        vecCount++; if (PredHitF !== 1'b1) begin missCount++; $display("FAIL alloc_hit got %b want 1", PredHitF); end
        vecCount++; if (PredTakenF !== 1'b1) begin missCount++; $display("FAIL alloc_taken got %b want 1", PredTakenF); end
        vecCount++; if (PC_In !== 32'h80) begin missCount++; $display("FAIL alloc_pc got %h want 00000080", PC_In); end
        vecCount++; if (MispredCnt !== 32'd1) begin missCount++; $display("FAIL alloc_miscnt got %0d want 1", MispredCnt); end
        // Predicted-taken branch resolved not-taken falls through
        PCF = 32'h104; PCE = 32'h100; BranchInstrE = 1; BranchE = 0; PredTakenE = 1;
        #1;
        vecCount++; if (MispredictE !== 1'b1) begin missCount++; $display("FAIL mis_nt got %b want 1", MispredictE); end
        vecCount++; if (PC_In !== 32'h104) begin missCount++; $display("FAIL mis_nt_pc got %h want 00000104", PC_In); end
        tick();
        clearInputs(); PCF = 32'h100; #1;
        vecCount++; if (PredTakenF !== 1'b0) begin missCount++; $display("FAIL weak_nt got %b want 0", PredTakenF); end
        vecCount++; if (PC_In !== 32'h104) begin missCount++; $display("FAIL weak_nt_pc got %h want 00000104", PC_In); end
    endtask

    task automatic test_saturation();
        // Three taken trainings from cnt=1 must stop at 3
        for (int n = 0; n < 3; n++) begin
            clearInputs(); PCF = 32'h20; PCE = 32'h100; BranchInstrE = 1; BranchE = 1;
            BranchTarget = 32'h80; PredTakenE = mTaken(32'h100);
            tick();
        end
        clearInputs(); PCF = 32'h20; PCE = 32'h100; BranchInstrE = 1; BranchE = 0; PredTakenE = 1;
        tick();
        clearInputs(); PCF = 32'h100; #1;
        vecCount++; if (PredTakenF !== 1'b1) begin missCount++; $display("FAIL sat_one_nt got %b want 1", PredTakenF); end
        PCE = 32'h100; BranchInstrE = 1; BranchE = 0; PredTakenE = 1; PCF = 32'h20;
        tick();
        clearInputs(); PCF = 32'h100; #1;
        vecCount++; if (PredTakenF !== 1'b0) begin missCount++; $display("FAIL sat_two_nt got %b want 0", PredTakenF); end
        vecCount++; if (BranchCnt !== 32'd7) begin missCount++; $display("FAIL sat_brcnt got %0d want 7", BranchCnt); end
    endtask

    task automatic test_aliasing();
        // Re-allocate 0x100 then replace it with 0x140 sharing index 0
        clearInputs(); PCE = 32'h100; BranchInstrE = 1; BranchE = 1; BranchTarget = 32'h80; PCF = 32'h20;
        tick();
        clearInputs(); PCE = 32'h140; BranchInstrE = 1; BranchE = 1; BranchTarget = 32'h300;
        PCF = 32'h140; #1;
        vecCount++; if (PredHitF !== 1'b0) begin missCount++; $display("FAIL nobypass_hit got %b want 0", PredHitF); end
        tick();
        clearInputs(); PCF = 32'h100; #1;
        vecCount++; if (PredHitF !== 1'b0) begin missCount++; $display("FAIL alias_old got %b want 0", PredHitF); end
        PCF = 32'h140; #1;
        vecCount++; if (PredHitF !== 1'b1) begin missCount++; $display("FAIL alias_new got %b want 1", PredHitF); end
        vecCount++; if (PC_In !== 32'h300) begin missCount++; $display("FAIL alias_pc got %h want 00000300", PC_In); end
    endtask

    task automatic test_priority_stall();
        int unsigned brBefore;
        clearInputs(); PCF = 32'h140;
        JalrE = 1; JalD = 1; JalrTarget = 32'hA000; JalTarget = 32'hB000;
        BranchInstrE = 1; BranchE = 1; PredTakenE = 0; BranchTarget = 32'hC000; PCE = 32'h188;
        #1;
        vecCount++; if (PC_In !== 32'hA000) begin missCount++; $display("FAIL prio_jalr got %h want 0000a000", PC_In); end
        JalrE = 0; #1;
        vecCount++; if (PC_In !== 32'hC000) begin missCount++; $display("FAIL prio_branch got %h want 0000c000", PC_In); end
        BranchInstrE = 0; #1;
        vecCount++; if (PC_In !== 32'hB000) begin missCount++; $display("FAIL prio_jal got %h want 0000b000", PC_In); end
        JalD = 0; #1;
        vecCount++; if (PC_In !== 32'h300) begin missCount++; $display("FAIL prio_pred got %h want 00000300", PC_In); end
        // Stalled branch: no training, no statistics, mispredict still flagged
        brBefore = mBr;
        BranchInstrE = 1; StallE = 1; #1;
        vecCount++; if (MispredictE !== 1'b1) begin missCount++; $display("FAIL stall_mis got %b want 1", MispredictE); end
        tick();
        clearInputs(); PCF = 32'h188; #1;
        vecCount++; if (PredHitF !== 1'b0) begin missCount++; $display("FAIL stall_hit got %b want 0", PredHitF); end
        vecCount++; if (BranchCnt !== brBefore) begin missCount++; $display("FAIL stall_brcnt got %0d want %0d", BranchCnt, brBefore); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clearInputs();
            PCF = 32'($urandom_range(0, 3) * 64 + $urandom_range(0, 15) * 4);
            PCE = 32'($urandom_range(0, 3) * 64 + $urandom_range(0, 15) * 4);
            BranchInstrE = ($urandom_range(0, 2) != 0);
            BranchE      = $urandom_range(0, 1);
            PredTakenE   = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : mTaken(PCE);
            StallE       = ($urandom_range(0, 7) == 0);
            JalD         = ($urandom_range(0, 7) == 0);
            JalrE        = ($urandom_range(0, 9) == 0);
            BranchTarget = $urandom & 32'hFFFF_FFFC;
            JalrTarget   = $urandom;
            JalTarget    = $urandom & 32'hFFFF_FFFC;
            if (n == 5) begin
                PCE = 32'hFFFF_FFFC; BranchInstrE = 1; BranchE = 0; PredTakenE = 1; JalrE = 0;
            end
            #1;
            vecCount++; if (PredHitF !== mHit(PCF)) begin missCount++; $display("FAIL rnd_hit n=%0d got %b want %b", n, PredHitF, mHit(PCF)); end
            vecCount++; if (PredTakenF !== mTaken(PCF)) begin missCount++; $display("FAIL rnd_taken n=%0d got %b want %b", n, PredTakenF, mTaken(PCF)); end
            vecCount++; if (PredTargetF !== mTarget(PCF)) begin missCount++; $display("FAIL rnd_tgt n=%0d got %h want %h", n, PredTargetF, mTarget(PCF)); end
            vecCount++; if (MispredictE !== (BranchInstrE && (BranchE != PredTakenE))) begin missCount++; $display("FAIL rnd_mis n=%0d got %b", n, MispredictE); end
            vecCount++; if (PC_In !== expPcIn()) begin missCount++; $display("FAIL rnd_pcin n=%0d got %h want %h", n, PC_In, expPcIn()); end
            vecCount++; if (BranchCnt !== mBr) begin missCount++; $display("FAIL rnd_brcnt n=%0d got %0d want %0d", n, BranchCnt, mBr); end
            vecCount++; if (MispredCnt !== mMis) begin missCount++; $display("FAIL rnd_miscnt n=%0d got %0d want %0d", n, MispredCnt, mMis); end
            tick();
        end
    endtask

    task automatic test_midreset();
        // Reset wins over a concurrent training request; combinational paths stay live
        clearInputs(); PCE = 32'h40; BranchInstrE = 1; BranchE = 1; PredTakenE = 0; BranchTarget = 32'h900;
        rst = 1; #1;
        vecCount++; if (MispredictE !== 1'b1) begin missCount++; $display("FAIL rst_mis got %b want 1", MispredictE); end
        vecCount++; if (PC_In !== 32'h900) begin missCount++; $display("FAIL rst_pcin got %h want 00000900", PC_In); end
        tick();
        rst = 0; clearInputs();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) begin
                PCF = 32'(t * 64 + i * 4); #1;
                vecCount++; if (PredHitF !== 1'b0 || PredTargetF !== PCF + 32'd4) begin missCount++; $display("FAIL rst_lookup pc=%h got hit=%b tgt=%h want 0/%h", PCF, PredHitF, PredTargetF, PCF + 32'd4); end
            end
        end
        vecCount++; if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0) begin missCount++; $display("FAIL rst_stats got %0d/%0d want 0/0", BranchCnt, MispredCnt); end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst = 1; PCF = '0;
        clearInputs();
        test_reset();
        test_mispredict();
        test_saturation();
        test_aliasing();
        test_priority_stall();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
